vector_list_writer: RTL and testbench

Builds the vector display list that the vector-display core reads from ROM/RAM. It accepts MOVE/DRAW commands over a valid/ready handshake and packs each one into a DATAWIDTH word. It writes the words sequentially from address 0 into the display-list RAM, closes every frame with a HALT word, and then pulses `go_flag` so the reader can start a new pass. It is the writer end of the display-list format that the reader walks until HALT.

---
 rtl/vector_list_writer.sv | 151 +++++++++++++++
 tb/tb_vector_list_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_list_writer.sv
// vector_list_writer
//   Writer end of the vector display list. Accepts MOVE/DRAW commands on a
//   valid/ready port, packs each one into a DATAWIDTH word
//   {opcode[1:0], x[OUT_WIDTH-1:0], y[OUT_WIDTH-1:0]}, writes the words
//   sequentially from address 0, terminates the list with a HALT word and
//   then pulses go_flag for one cycle so the reader may start a new pass.
//
//   Optional feature macro: VECTOR_DEDUP_EN
//     When defined, a MOVE accepted directly after another MOVE in the same
//     frame overwrites the previous word (written at pointer-1, pointer holds).
//
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is a function of state and pointer
//   only and never looks at cmd_valid; the producer must hold its command
//   stable until the transfer edge. While the list is full cmd_ready stays
//   low, any offered command is dropped and sets the sticky overflow flag.
//
//   fsm_state exposes the controller state (0 IDLE, 1 FILL, 2 CLOSE, 3 DONE).
module vector_list_writer #(
   parameter int ADDRESSWIDTH = 10,
   parameter int OUT_WIDTH    = 8,
   parameter int DATAWIDTH    = 18
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  logic                    frame_end,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_draw,
   input  logic [OUT_WIDTH-1:0]    cmd_x,
   input  logic [OUT_WIDTH-1:0]    cmd_y,
   output logic                    wr_en,
   output logic [ADDRESSWIDTH-1:0] wr_addr,
   output logic [DATAWIDTH-1:0]    wr_data,
   output logic                    go_flag,
   output logic                    busy,
   output logic                    overflow,
   output logic [ADDRESSWIDTH:0]   list_len,
   output logic [1:0]              fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CLOSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_DRAW = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;

   // Highest address is kept free so the HALT word always fits.
   localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = '1;

   state_t                  state;
   logic [ADDRESSWIDTH-1:0] ptr;
   logic                    accept;
   logic                    merge;
   logic [DATAWIDTH-1:0]    cmd_word;
   logic [DATAWIDTH-1:0]    halt_word;

   assign cmd_ready = (state == S_FILL) && (ptr != LAST_ADDR);
   assign accept    = cmd_valid && cmd_ready;
   assign cmd_word  = {(cmd_draw ? OP_DRAW : OP_MOVE), cmd_x, cmd_y};
   assign halt_word = {OP_HALT, {(DATAWIDTH-2){1'b0}}};
   assign fsm_state = state;

`ifdef VECTOR_DEDUP_EN
   logic last_move;

   // A MOVE directly following an accepted MOVE replaces it in place.
   assign merge = accept && !cmd_draw && last_move;

   // Remember whether the most recently accepted word of this frame was a MOVE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_move <= 1'b0;
      end else if (state == S_IDLE && frame_start) begin
         last_move <= 1'b0;
      end else if (accept) begin
         last_move <= !cmd_draw;
      end
   end
`else
   assign merge = 1'b0;
`endif

   // Controller: frame sequencing, pointer, registered write port and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ptr      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         go_flag  <= 1'b0;
         busy     <= 1'b0;
         overflow <= 1'b0;
         list_len <= '0;
      end else begin
         wr_en   <= 1'b0;
         go_flag <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state    <= S_FILL;
                  ptr      <= '0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_FILL: begin
               if (accept) begin
                  wr_en   <= 1'b1;
                  wr_data <= cmd_word;
                  if (merge) begin
                     wr_addr <= ptr - 1'b1;
                  end else begin
                     wr_addr <= ptr;
                     ptr     <= ptr + 1'b1;
                  end
               end else if (cmd_valid) begin
                  // Only reachable when the list is full: drop and flag.
                  overflow <= 1'b1;
               end
               if (frame_end) begin
                  state <= S_CLOSE;
               end
            end
            S_CLOSE: begin
               wr_en    <= 1'b1;
               wr_addr  <= ptr;
               wr_data  <= halt_word;
               list_len <= {1'b0, ptr} + 1'b1;
               busy     <= 1'b0;
               state    <= S_DONE;
            end
            S_DONE: begin
               go_flag <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_list_writer.sv
// tb_vector_list_writer
//   Directed bench for vector_list_writer. Two instances share the clock and
//   reset: a default-sized one (ADDRESSWIDTH 10) and a small one
//   (ADDRESSWIDTH 3) used for the full-list behaviour. Writes seen on either
//   RAM port are collected as {addr[9:0], data[17:0]} and compared with a
//   hand-built expected queue.
module tb_vector_list_writer;

   localparam int AW  = 10;
   localparam int SAW = 3;
   localparam int OW  = 8;
   localparam int DW  = 18;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_DRAW = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- main instance ----------------
   logic          frame_start, frame_end, cmd_valid, cmd_draw;
   logic [OW-1:0] cmd_x, cmd_y;
   logic          cmd_ready, wr_en, go_flag, busy, overflow;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0]   list_len;
   logic [1:0]    fsm_state;

   vector_list_writer #(.ADDRESSWIDTH(AW), .OUT_WIDTH(OW), .DATAWIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_draw(cmd_draw),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .go_flag(go_flag), .busy(busy), .overflow(overflow),
      .list_len(list_len), .fsm_state(fsm_state)
   );

   // ---------------- small instance ----------------
   logic           s_frame_start, s_frame_end, s_cmd_valid, s_cmd_draw;
   logic [OW-1:0]  s_cmd_x, s_cmd_y;
   logic           s_cmd_ready, s_wr_en, s_go_flag, s_busy, s_overflow;
   logic [SAW-1:0] s_wr_addr;
   logic [DW-1:0]  s_wr_data;
   logic [SAW:0]   s_list_len;
   logic [1:0]     s_fsm_state;

   vector_list_writer #(.ADDRESSWIDTH(SAW), .OUT_WIDTH(OW), .DATAWIDTH(DW)) sdut (
      .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start), .frame_end(s_frame_end),
      .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_draw(s_cmd_draw),
      .cmd_x(s_cmd_x), .cmd_y(s_cmd_y), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
      .wr_data(s_wr_data), .go_flag(s_go_flag), .busy(s_busy), .overflow(s_overflow),
      .list_len(s_list_len), .fsm_state(s_fsm_state)
   );

   // ---------------- scoreboard ----------------
   logic [27:0] exp_q[$];
   logic [27:0] obs_q[$];
   int          obs_cyc[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk) cyc = cyc + 1;

   // A write strobe seen between edges is captured by the RAM at the next edge.
   always @(negedge clk) begin
      if (wr_en) begin
         obs_q.push_back({wr_addr, wr_data});
         obs_cyc.push_back(cyc);
      end
      if (s_wr_en) begin
         obs_q.push_back({7'd0, s_wr_addr, s_wr_data});
         obs_cyc.push_back(cyc);
      end
   end

   function automatic logic [DW-1:0] word(input logic [1:0] op, input logic [7:0] x,
                                          input logic [7:0] y);
      return {op, x, y};
   endfunction

   function automatic logic [27:0] ent(input int a, input logic [DW-1:0] d);
      logic [9:0] a10;
      a10 = a[9:0];
      return {a10, d};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      int n;
      check({tag, " write count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s write %0d", tag, i), obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
      obs_cyc.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic d, input logic [7:0] x, input logic [7:0] y);
      cmd_valid = 1'b1;
      cmd_draw  = d;
      cmd_x     = x;
      cmd_y     = y;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic open_frame(input bit sel);
      @(negedge clk);
      if (sel) s_frame_start = 1'b1; else frame_start = 1'b1;
      @(negedge clk);
      s_frame_start = 1'b0;
      frame_start   = 1'b0;
   endtask

   // Called at the negedge where frame_end was just raised; go_flag must
   // appear three edges later and last exactly one cycle.
   task automatic wait_go(input bit sel, input string tag);
      int c;
      c = 0;
      while (!(sel ? s_go_flag : go_flag) && c < 30) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            cmd_valid   = 1'b0;
            frame_end   = 1'b0;
            s_cmd_valid = 1'b0;
            s_frame_end = 1'b0;
            check({tag, " busy in close"}, sel ? s_busy : busy, 1'b1);
         end
      end
      check({tag, " go latency"}, c, 3);
      @(negedge clk);
      check({tag, " go pulse width"}, sel ? s_go_flag : go_flag, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      frame_start = 0; frame_end = 0; cmd_valid = 0; cmd_draw = 0; cmd_x = 0; cmd_y = 0;
      s_frame_start = 0; s_frame_end = 0; s_cmd_valid = 0; s_cmd_draw = 0;
      s_cmd_x = 0; s_cmd_y = 0;
      repeat (2) @(negedge clk);

      // reset values
      check("rst cmd_ready", cmd_ready, 1'b0);
      check("rst wr_en", wr_en, 1'b0);
      check("rst wr_addr", wr_addr, 0);
      check("rst wr_data", wr_data, 0);
      check("rst go_flag", go_flag, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst overflow", overflow, 1'b0);
      check("rst list_len", list_len, 0);
      check("rst state", fsm_state, 2'd0);
      check("rst small state", s_fsm_state, 2'd0);
      rst_n = 1'b1;

      // T1: DRAW(10,20), MOVE(150,150), close
      open_frame(0);
      check("t1 busy", busy, 1'b1);
      check("t1 ready", cmd_ready, 1'b1);
      check("t1 state fill", fsm_state, 2'd1);
      send(1'b1, 8'd10, 8'd20);
      send(1'b0, 8'd150, 8'd150);
      frame_end = 1'b1;
      wait_go(0, "t1");
      check("t1 list_len", list_len, 3);
      check("t1 idle after go", fsm_state, 2'd0);
      exp_q.push_back(ent(0, 18'h10A14));
      exp_q.push_back(ent(1, 18'h09696));
      exp_q.push_back(ent(2, 18'h20000));
      check_writes("t1");

      // frame_end and cmd_valid in IDLE are ignored
      frame_end = 1'b1; cmd_valid = 1'b1;
      @(negedge clk);
      frame_end = 1'b0; cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("idle ignores end", fsm_state, 2'd0);
      check_writes("idle");

      // T2: empty frame, frame_end right after frame_start
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      frame_end   = 1'b1;
      wait_go(0, "t2");
      check("t2 list_len", list_len, 1);
      exp_q.push_back(ent(0, word(OP_HALT, 8'd0, 8'd0)));
      check_writes("t2");

      // T3: small list, 10 cycles of continuous valid
      open_frame(1);
      for (int i = 0; i < 10; i++) begin
         s_cmd_valid = 1'b1;
         s_cmd_draw  = 1'b1;
         s_cmd_x     = 8'(i * 3);
         s_cmd_y     = 8'(i + 100);
         check($sformatf("t3 ready %0d", i), s_cmd_ready, (i < 7) ? 1'b1 : 1'b0);
         if (i < 7) exp_q.push_back(ent(i, word(OP_DRAW, 8'(i * 3), 8'(i + 100))));
         @(negedge clk);
      end
      s_cmd_valid = 1'b0;
      check("t3 overflow", s_overflow, 1'b1);
      s_frame_end = 1'b1;
      wait_go(1, "t3");
      check("t3 list_len", s_list_len, 8);
      check("t3 overflow sticky", s_overflow, 1'b1);
      exp_q.push_back(ent(7, word(OP_HALT, 8'd0, 8'd0)));
      check_writes("t3");

      // next small frame clears overflow
      open_frame(1);
      check("t3b overflow cleared", s_overflow, 1'b0);
      check("t3b ready", s_cmd_ready, 1'b1);
      s_frame_end = 1'b1;
      wait_go(1, "t3b");
      check("t3b list_len", s_list_len, 1);
      exp_q.push_back(ent(0, word(OP_HALT, 8'd0, 8'd0)));
      check_writes("t3b");

      // T4: last handshake together with frame_end
      open_frame(0);
      send(1'b1, 8'd1, 8'd2);
      cmd_valid = 1'b1; cmd_draw = 1'b0; cmd_x = 8'd3; cmd_y = 8'd4;
      frame_end = 1'b1;
      wait_go(0, "t4");
      check("t4 list_len", list_len, 3);
      if (obs_cyc.size() >= 3)
         check("t4 halt on next edge", obs_cyc[2] - obs_cyc[1], 1);
      else
         check("t4 write events", obs_cyc.size(), 3);
      exp_q.push_back(ent(0, word(OP_DRAW, 8'd1, 8'd2)));
      exp_q.push_back(ent(1, word(OP_MOVE, 8'd3, 8'd4)));
      exp_q.push_back(ent(2, word(OP_HALT, 8'd0, 8'd0)));
      check_writes("t4");

      // T5: reset in mid-frame after 4 commands
      open_frame(0);
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 8'(i + 40), 8'(i + 50));
         exp_q.push_back(ent(i, word(OP_DRAW, 8'(i + 40), 8'(i + 50))));
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("t5 wr_en", wr_en, 1'b0);
      check("t5 wr_addr", wr_addr, 0);
      check("t5 wr_data", wr_data, 0);
      check("t5 busy", busy, 1'b0);
      check("t5 ready", cmd_ready, 1'b0);
      check("t5 list_len", list_len, 0);
      check("t5 state", fsm_state, 2'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_writes("t5 no halt");
      open_frame(0);
      send(1'b1, 8'd5, 8'd5);
      frame_end = 1'b1;
      wait_go(0, "t5b");
      check("t5b list_len", list_len, 2);
      exp_q.push_back(ent(0, word(OP_DRAW, 8'd5, 8'd5)));
      exp_q.push_back(ent(1, word(OP_HALT, 8'd0, 8'd0)));
      check_writes("t5b");

      // T6: MOVE(1,1), MOVE(2,2), DRAW(3,3)
      open_frame(0);
      send(1'b0, 8'd1, 8'd1);
      send(1'b0, 8'd2, 8'd2);
      send(1'b1, 8'd3, 8'd3);
      frame_end = 1'b1;
      wait_go(0, "t6");
      exp_q.push_back(ent(0, word(OP_MOVE, 8'd1, 8'd1)));
`ifdef VECTOR_DEDUP_EN
      check("t6 list_len", list_len, 3);
      exp_q.push_back(ent(0, word(OP_MOVE, 8'd2, 8'd2)));
      exp_q.push_back(ent(1, word(OP_DRAW, 8'd3, 8'd3)));
      exp_q.push_back(ent(2, word(OP_HALT, 8'd0, 8'd0)));
`else
      check("t6 list_len", list_len, 4);
      exp_q.push_back(ent(1, word(OP_MOVE, 8'd2, 8'd2)));
      exp_q.push_back(ent(2, word(OP_DRAW, 8'd3, 8'd3)));
      exp_q.push_back(ent(3, word(OP_HALT, 8'd0, 8'd0)));
`endif
      check_writes("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
